// File: rtl/flash_param_fetch.sv
// flash_param_fetch: walks the parameter flash image and streams tagged words to the MAC/ALU datapath.
// Latency: address valid one cycle after start, first word WAIT_CYCLES later; one word per WAIT_CYCLES.
// Backpressure: 2-entry FIFO, flash address holds and re-samples while full. Optional: PARAM_CHECKSUM_EN.
module flash_param_fetch #(
   parameter int WAIT_CYCLES = 2,
   parameter int HID_NEURONS = 8,
   parameter int HID_WORDS   = 36,
   parameter int OUT_NEURONS = 10,
   parameter int OUT_WORDS   = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   output logic [15:0] address,
   input  logic [15:0] data,
   output logic        ce,
   output logic        oe,
   output logic        we,
   output logic [15:0] word_data,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        is_bias,
   output logic        last_word,
   output logic        layer,
   output logic [3:0]  neuron_idx,
   output logic        busy,
   output logic        done,
   output logic [15:0] checksum
);

   localparam int TOTAL = HID_NEURONS * (HID_WORDS + 1) + OUT_NEURONS * (OUT_WORDS + 1);
   localparam logic [15:0] LAST_ADDR = 16'(TOTAL - 1);
   localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
   localparam int MAXW = (HID_WORDS > OUT_WORDS) ? HID_WORDS : OUT_WORDS;
   localparam int PW = $clog2(MAXW + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

   typedef struct packed {
      logic [15:0] dat;
      logic        is_bias;
      logic        last_word;
      logic        layer;
      logic [3:0]  neuron_idx;
   } entry_t;

   state_t        state, state_nxt;
   logic [WW-1:0] wait_cnt;
   logic [PW-1:0] pos_cnt;
   logic [3:0]    nrn_cnt;
   logic          lay;
   entry_t        mem [2];
   entry_t        head, wr_entry;
   logic          rd_ptr, wr_ptr;
   logic [1:0]    count;
   logic          push, pop, pos_last, nrn_last;

   assign pos_last = lay ? (pos_cnt == PW'(OUT_WORDS)) : (pos_cnt == PW'(HID_WORDS));
   assign nrn_last = lay ? (nrn_cnt == 4'(OUT_NEURONS - 1)) : (nrn_cnt == 4'(HID_NEURONS - 1));

   assign pop  = word_valid && word_ready;
   // ce doubles as "address has been stable since the wait counter started"
   assign push = (state == FETCH) && ce && (wait_cnt == WAIT_LAST) && ((count != 2'd2) || pop);

   assign wr_entry = '{dat: data, is_bias: (pos_cnt == '0), last_word: pos_last,
                       layer: lay, neuron_idx: nrn_cnt};

   assign head       = mem[rd_ptr];
   assign word_data  = head.dat;
   assign is_bias    = head.is_bias;
   assign last_word  = head.last_word;
   assign layer      = head.layer;
   assign neuron_idx = head.neuron_idx;
   assign word_valid = (count != 2'd0);
   assign oe         = ce;
   assign we         = 1'b0;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = FETCH;
         end
         FETCH: begin
            busy = 1'b1;
            if (push && (address == LAST_ADDR)) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (count == 2'd0) state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state    <= IDLE;
         ce       <= 1'b0;
         address  <= '0;
         wait_cnt <= '0;
         pos_cnt  <= '0;
         nrn_cnt  <= '0;
         lay      <= 1'b0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         count    <= 2'd0;
         mem[0]   <= '0;
         mem[1]   <= '0;
      end else begin
         state <= state_nxt;
         ce    <= (state == FETCH) && (state_nxt == FETCH);

         if ((state == IDLE) && start) begin
            address  <= '0;
            wait_cnt <= '0;
            pos_cnt  <= '0;
            nrn_cnt  <= '0;
            lay      <= 1'b0;
         end else if (push) begin
            address  <= (address == LAST_ADDR) ? 16'd0 : address + 16'd1;
            wait_cnt <= '0;
            if (pos_last) begin
               pos_cnt <= '0;
               if (nrn_last) begin
                  nrn_cnt <= '0;
                  lay     <= 1'b1;
               end else begin
                  nrn_cnt <= nrn_cnt + 4'd1;
               end
            end else begin
               pos_cnt <= pos_cnt + PW'(1);
            end
         end else if ((state == FETCH) && ce && (wait_cnt != WAIT_LAST)) begin
            wait_cnt <= wait_cnt + WW'(1);
         end

         if (push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef PARAM_CHECKSUM_EN
   logic [15:0] csum;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         csum <= '0;
      end else if ((state == IDLE) && start) begin
         csum <= '0;
      end else if (push) begin
         csum <= csum + data;
      end
   end

   assign checksum = csum;
`else
   assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_flash_param_fetch.sv
// Bench for flash_param_fetch: flash array model, layout-derived reference for tags, directed runs with random data/ready.
module tb_flash_param_fetch;

   localparam int NW = 326;

   logic        clk = 1'b0;
   logic        n_rst, start, word_ready;
   logic [15:0] address, data, word_data, checksum;
   logic        ce, oe, we, word_valid, is_bias, last_word, layer, busy, done;
   logic [3:0]  neuron_idx;

   logic [15:0] img [0:511];
   int checks = 0;
   int errors = 0;
   int exp_idx;
   int dk;

   always #5 clk = ~clk;

   assign data = img[address[8:0]];

   flash_param_fetch dut (
      .clk(clk), .n_rst(n_rst), .start(start), .address(address), .data(data),
      .ce(ce), .oe(oe), .we(we), .word_data(word_data), .word_valid(word_valid),
      .word_ready(word_ready), .is_bias(is_bias), .last_word(last_word), .layer(layer),
      .neuron_idx(neuron_idx), .busy(busy), .done(done), .checksum(checksum)
   );

   // Expected head word for image address a, from the image layout arithmetic.
   function automatic logic [22:0] model(input int a);
      int n, p, last_p;
      logic l;
      if (a < 296) begin
         l = 1'b0; n = a / 37; p = a % 37; last_p = 36;
      end else begin
         l = 1'b1; n = (a - 296) / 3; p = (a - 296) % 3; last_p = 2;
      end
      return {img[a], (p == 0), (p == last_p), l, 4'(n)};
   endfunction

   function automatic logic [15:0] exp_checksum();
      logic [15:0] s = 16'd0;
`ifdef PARAM_CHECKSUM_EN
      for (int a = 0; a < NW; a++) s = s + img[a];
`endif
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Called at a negedge: a word visible with ready high is accepted at the coming edge.
   task automatic sample();
      if (word_valid && word_ready) begin
         check("word_in_range", 32'(exp_idx < NW), 32'd1);
         if (exp_idx < NW)
            check("word", {9'd0, word_data, is_bias, last_word, layer, neuron_idx},
                  {9'd0, model(exp_idx)});
         exp_idx++;
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: 20-cycle stall after first valid word
   task automatic run(input int mode, output int done_k);
      int k, fv;
      bit done_seen;
      logic [15:0] cs;
      cs = exp_checksum();
      exp_idx = 0;
      fv = -1;
      done_seen = 0;
      done_k = -1;
      @(negedge clk);
      start = 1'b1;
      word_ready = (mode == 0);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done_seen && k < 4000) begin
         start = (k == 100);
         if (mode == 1) word_ready = 1'($urandom_range(0, 1));
         if (mode == 2) begin
            if (fv < 0 && word_valid) fv = k;
            word_ready = (fv >= 0) && (k >= fv + 20);
            if (fv >= 0 && k < fv + 20) begin
               check("stall_data", 32'(word_data), 32'd0);
               check("stall_valid", 32'(word_valid), 32'd1);
            end
            if (fv >= 0 && k == fv + 19) begin
               check("stall_addr", 32'(address), 32'd2);
               check("stall_ce", 32'(ce), 32'd1);
            end
         end
         if (mode == 0) begin
            if (k == 0) check("busy_rise", 32'(busy), 32'd1);
            if (k == 1) begin
               check("lat_ce", 32'(ce), 32'd1);
               check("lat_oe", 32'(oe), 32'd1);
               check("lat_addr", 32'(address), 32'd0);
            end
            if (k == 2) check("valid_early", 32'(word_valid), 32'd0);
            if (k == 3) check("valid_first", 32'(word_valid), 32'd1);
         end
         sample();
         if (done) begin
            done_seen = 1;
            done_k = k;
            check("words_at_done", 32'(exp_idx), NW);
            check("checksum", 32'(checksum), 32'(cs));
            check("busy_at_done", 32'(busy), 32'd0);
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check("done_seen", 32'(done_seen), 32'd1);
      check("done_once", 32'(done), 32'd0);
      check("checksum_hold", 32'(checksum), 32'(cs));
   endtask

   initial begin
      n_rst = 1'b0;
      start = 1'b1;
      word_ready = 1'b0;
      for (int a = 0; a < 512; a++) img[a] = 16'(a);

      // reset with start held high
      repeat (2) @(negedge clk);
      check("rst_out", {7'd0, address, ce, oe, we, word_valid, word_data, is_bias,
                        last_word, layer, neuron_idx, busy, done},
            32'd0);
      check("rst_checksum", 32'(checksum), 32'd0);
      n_rst = 1'b1;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("no_fetch_busy", 32'(busy), 32'd0);
         check("no_fetch_ce", 32'(ce), 32'd0);
      end

      run(0, dk);
      check("done_latency", dk, 655);

      run(2, dk);

      for (int a = 0; a < NW; a++) img[a] = 16'($urandom);
      run(1, dk);
      for (int a = 0; a < 512; a++) img[a] = 16'(a);

      // abort at word 100
      @(negedge clk);
      start = 1'b1;
      word_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_idx = 0;
      for (int i = 0; i < 1000 && exp_idx < 100; i++) begin
         sample();
         @(negedge clk);
      end
      check("abort_reach", 32'(exp_idx), 32'd100);
      n_rst = 1'b0;
      @(negedge clk);
      check("abort_rst", {11'd0, address, ce, oe, word_valid, busy, done}, 32'd0);
      check("abort_data", 32'(word_data), 32'd0);
      check("abort_checksum", 32'(checksum), 32'd0);
      n_rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end
      run(0, dk);
      check("restart_latency", dk, 655);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flash_param_fetch.md
# flash_param_fetch

Sequencer between the external parameter flash and the digit recognizer's MAC/ALU datapath. On `start` it walks the 326-word parameter image, driving `address`/`ce`/`oe`, and pushes each word into a 2-entry prefetch FIFO. The FIFO presents each word to the consumer under a valid/ready handshake, with tags for layer, neuron and position.

- Parameter image layout: 8 hidden neurons × (1 bias + 36 weight words), then 10 output neurons × (1 bias + 2 weight words).
- Each weight word packs four 4-bit weights.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: cycles `address` is held stable before `data` is sampled (≥1).
- `HID_NEURONS`, 8: hidden neurons.
- `HID_WORDS`, 36: weight words per hidden neuron.
- `OUT_NEURONS`, 10: output neurons.
- `OUT_WORDS`, 2: weight words per output neuron.

Ports:
- `clk` in 1: system clock. Single clock; everything is on the rising edge.
- `n_rst` in 1: reset. Synchronous and active-low.
- `start` in 1: one-cycle pulse that begins a full fetch. Ignored while `busy`.
- `address` out 16: flash word address.
- `data` in 16: flash read data. Combinational from `address`.
- `ce` out 1: flash chip enable, active-high.
- `oe` out 1: flash output enable, active-high.
- `we` out 1: flash write enable. Constant 0.
- `word_data` out 16: FIFO head word.
- `word_valid` out 1: FIFO head is valid.
- `word_ready` in 1: consumer accepts the head word.
- `is_bias` out 1: head word is a neuron bias.
- `last_word` out 1: head word is the last word of its neuron.
- `layer` out 1: 0 = hidden, 1 = output.
- `neuron_idx` out 4: neuron index within the layer.
- `busy` out 1: fetch in progress, or FIFO not yet drained.
- `done` out 1: one-cycle pulse when the last word has been accepted.
- `checksum` out 16: see Configuration.

## Operation
- State machine has four states: IDLE, FETCH, DRAIN, FINISH.
- IDLE: `ce`=`oe`=0, `address`=0.
  - `start` → FETCH. Clears word counter, wait counter and checksum.
- FETCH: `ce`=`oe`=1. `address` equals the word counter, held stable.
  - The wait counter counts 0..WAIT_CYCLES-1.
  - In the last wait cycle, if the FIFO has space (count<2, or a pop occurs this cycle):
    - `data` and its tags are written into the FIFO;
    - the word counter increments;
    - the wait counter clears.
  - Otherwise the address is held, the wait counter saturates, and the sample retries each cycle.
  - After address 325 is captured → DRAIN.
- DRAIN: `ce`=`oe`=0. When the FIFO is empty → FINISH.
- FINISH: `done`=1 for one cycle → IDLE.
- Tags are derived from nested counters:
  - word position 0 in a neuron → `is_bias`=1;
  - position HID_WORDS (hidden layer) or OUT_WORDS (output layer) → `last_word`=1;
  - `neuron_idx` wraps to 0 and `layer` goes to 1 at address 296.
- FIFO: depth 2, with read and write pointers plus a count.
  - Pop condition: `word_valid`&&`word_ready`.
  - A push and a pop in the same cycle while full is legal; count stays 2.
- `word_valid`, `word_data` and the tags are registered FIFO outputs. They are stable while `word_valid`&&!`word_ready`.

## Timing
- Reset (`n_rst`=0 at a clock edge) forces the following outputs to 0:
  - state → IDLE;
  - `address`, `ce`, `oe`, `we`;
  - `word_valid`, `word_data`, tags;
  - `busy`, `done`, `checksum`.
  - FIFO is flushed. Applies mid-fetch too; no partial `done` is produced.
- Latency:
  - `start` at edge N → `address`=0 with `ce`=1 after edge N+1.
  - First `word_valid`=1 after edge N+1+WAIT_CYCLES.
- Throughput: one word per WAIT_CYCLES cycles when the consumer never stalls.
  - Full image, `word_ready`=1, WAIT_CYCLES=2: `done` pulses 1+652+2 cycles after `start`.
- `busy` rises the cycle after `start` and falls together with the `done` pulse.
- `start` during FETCH, DRAIN or FINISH is ignored; it is not queued.
- `word_ready` while `word_valid`=0 has no effect.

## Configuration
- `PARAM_CHECKSUM_EN`, defined: `checksum` accumulates the modulo-2^16 sum of every word written to the FIFO.
  - Cleared on `start`.
  - Final value is valid from the `done` pulse until the next `start` or reset.
- `PARAM_CHECKSUM_EN`, undefined: no accumulator is built and `checksum` is tied to 0.

## Test plan
- Reset: hold `n_rst`=0 for 2 cycles → all outputs 0 and state IDLE. `start` while `n_rst`=0 → no fetch.
- Full fetch, `word_ready`=1, WAIT_CYCLES=2, flash word k = k:
  - 326 words, values 0..325 in order;
  - `is_bias` exactly at addresses 0, 37, …, 259, 296, 299, …, 323;
  - `last_word` at 36, 73, …, 295, 298, …, 325;
  - `neuron_idx` 0..7 in layer 0, then 0..9 in layer 1;
  - `done` 655 cycles after `start`.
- Backpressure: `word_ready`=0 for 20 cycles after the first valid word →
  - FIFO fills to 2;
  - `address` holds at 2 with `ce`=1;
  - `word_data` is stable at 0;
  - on release, words 0,1,2… arrive with no loss or duplication.
- Random `word_ready` (50%) over a full fetch → the word sequence and tags are identical to the no-stall run.
- Reset asserted at word 100, then `start` → fetch restarts from address 0; no `done` from the aborted run.
- With `PARAM_CHECKSUM_EN` and flash word k = k → `checksum`=52975 (sum 0..325) at `done`. Without the macro → 0.
